register_file: RTL and testbench

- General-purpose register file: 8 registers of WORD_LENGTH bits.
- One synchronous write port and two independent combinational read ports.
- Serves as the operand store of the datapath. Read ports feed the ALU operand muxes; the write port is driven by the writeback stage.

---
 rtl/register_file.sv | 49 ++++
 tb/tb_register_file.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file: 2**ADDR_WIDTH x WORD_LENGTH operand store, one write, two reads.
// Define ZERO_REG_EN to hardwire register 0 to zero.
module register_file #(
  parameter int WORD_LENGTH = 8,
  parameter int ADDR_WIDTH  = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   reg_Write,
  input  logic [ADDR_WIDTH-1:0]  Write_Register,
  input  logic [WORD_LENGTH-1:0] Write_Data,
  input  logic [ADDR_WIDTH-1:0]  Read_Register_1,
  input  logic [ADDR_WIDTH-1:0]  Read_Register_2,
  output logic [WORD_LENGTH-1:0] Read_Data_1,
  output logic [WORD_LENGTH-1:0] Read_Data_2
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic [WORD_LENGTH-1:0] regs [NREG];
  logic                   wr_en;

`ifdef ZERO_REG_EN
  assign wr_en = reg_Write && (Write_Register != '0);
`else
  assign wr_en = reg_Write;
`endif

  // reset has priority, so an edge that meets reset never writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (wr_en) begin
      regs[Write_Register] <= Write_Data;
    end
  end

`ifdef ZERO_REG_EN
  assign Read_Data_1 = (Read_Register_1 == '0) ? '0
                     : regs[Read_Register_1];
  assign Read_Data_2 = (Read_Register_2 == '0) ? '0
                     : regs[Read_Register_2];
`else
  assign Read_Data_1 = regs[Read_Register_1];
  assign Read_Data_2 = regs[Read_Register_2];
`endif

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: scoreboard bench for register_file.
// Expected read data is queued at drive time and compared after settle.
module tb_register_file;

  logic       clk = 1'b0;
  logic       reset;
  logic       reg_Write;
  logic [2:0] Write_Register;
  logic [7:0] Write_Data;
  logic [2:0] Read_Register_1;
  logic [2:0] Read_Register_2;
  logic [7:0] Read_Data_1;
  logic [7:0] Read_Data_2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] exp;
    bit         port;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model [8];

  register_file dut (
    .clk             (clk),
    .reset           (reset),
    .reg_Write       (reg_Write),
    .Write_Register  (Write_Register),
    .Write_Data      (Write_Data),
    .Read_Register_1 (Read_Register_1),
    .Read_Register_2 (Read_Register_2),
    .Read_Data_1     (Read_Data_1),
    .Read_Data_2     (Read_Data_2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_rd(input logic [2:0] a);
`ifdef ZERO_REG_EN
    if (a == 3'd0) return 8'd0;
`endif
    return model[a];
  endfunction

  task automatic drain();
    exp_t       e;
    logic [7:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = e.port ? Read_Data_2 : Read_Data_1;
      check(e.tag, obs, e.exp);
    end
  endtask

  task automatic push(input string tag,
                      input logic [2:0] a1,
                      input logic [2:0] a2);
    sb.push_back('{tag: {tag, "_p1"}, exp: exp_rd(a1), port: 1'b0});
    sb.push_back('{tag: {tag, "_p2"}, exp: exp_rd(a2), port: 1'b1});
  endtask

  task automatic rd(input string tag,
                    input logic [2:0] a1,
                    input logic [2:0] a2);
    Read_Register_1 = a1;
    Read_Register_2 = a2;
    push(tag, a1, a2);
    #1;
    drain();
  endtask

  task automatic wr(input logic we,
                    input logic [2:0] a,
                    input logic [7:0] d);
    @(negedge clk);
    reg_Write      = we;
    Write_Register = a;
    Write_Data     = d;
    @(posedge clk);
    if (!reset && we) begin
`ifdef ZERO_REG_EN
      if (a != 3'd0) model[a] = d;
`else
      model[a] = d;
`endif
    end
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) model[i] = 8'd0;
  endtask

  initial begin
    reset           = 1'b1;
    reg_Write       = 1'b0;
    Write_Register  = '0;
    Write_Data      = '0;
    Read_Register_1 = '0;
    Read_Register_2 = '0;
    clear_model();
    #2;
    rd("rst_init_a", 3'd0, 3'd7);
    rd("rst_init_b", 3'd3, 3'd5);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) wr(1'b1, i[2:0], 8'hFF);
    wr(1'b0, 3'd0, 8'h00);
    for (int i = 0; i < 8; i++) rd("fill", i[2:0], 3'(7 - i));

    @(negedge clk);
    #2;
    reset = 1'b1;
    clear_model();
    rd("async_clr", 3'd1, 3'd6);
    for (int i = 0; i < 8; i++) rd("clr", i[2:0], 3'(7 - i));
    wr(1'b1, 3'd3, 8'h55);
    wr(1'b1, 3'd4, 8'h66);
    rd("wr_in_rst", 3'd3, 3'd4);
    @(negedge clk);
    reset = 1'b0;

    wr(1'b1, 3'd2, 8'd3);
    wr(1'b1, 3'd4, 8'd2);
    wr(1'b1, 3'd5, 8'd20);
    wr(1'b1, 3'd6, 8'd6);
    wr(1'b1, 3'd7, 8'd78);
    reg_Write = 1'b0;
    rd("basic_2", 3'd2, 3'd2);
    rd("basic_4", 3'd4, 3'd4);
    rd("basic_5", 3'd5, 3'd5);
    rd("basic_6", 3'd6, 3'd6);
    rd("basic_7", 3'd7, 3'd7);

    repeat (3) wr(1'b0, 3'd5, 8'd99);
    rd("wr_dis", 3'd5, 3'd5);

    rd("dual_2_7", 3'd2, 3'd7);
    rd("dual_4_4", 3'd4, 3'd4);

    Read_Register_1 = 3'd6;
    Read_Register_2 = 3'd2;
    @(negedge clk);
    reg_Write      = 1'b1;
    Write_Register = 3'd6;
    Write_Data     = 8'd55;
    push("rdw_pre", 3'd6, 3'd2);
    #1;
    drain();
    @(posedge clk);
    model[6] = 8'd55;
    #1;
    push("rdw_post", 3'd6, 3'd2);
    drain();
    reg_Write = 1'b0;

    wr(1'b1, 3'd1, 8'hA5);
    wr(1'b1, 3'd1, 8'h5A);
    rd("last_wins", 3'd1, 3'd7);

    wr(1'b1, 3'd0, 8'd42);
    reg_Write = 1'b0;
    rd("zero_reg", 3'd0, 3'd0);
    rd("zero_mix", 3'd0, 3'd6);

    for (int k = 0; k < 20; k++) begin
      wr(1'b1, 3'($urandom_range(0, 7)), 8'($urandom));
      rd("rand", 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
